// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
// Control bundle order: pc, ifid_en, ifid_flush, idex_en, idex_bubble, exmem, memwb.
package pipe_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] FLUSH    = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int WCNT_W = 8;
  localparam int FCNT_W = 3;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_en;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN    = 7'b1101011;
  localparam pipe_ctl_t CTL_STALL  = 7'b0001111;
  localparam pipe_ctl_t CTL_FLUSH  = 7'b1111111;
  localparam pipe_ctl_t CTL_FREEZE = 7'b0000000;
  localparam pipe_ctl_t CTL_RESET  = 7'b0010100;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage-register controls of the pipeline sequencer.
// PIPE_PERF_CNT_EN adds the stall/flush/freeze performance counters.
interface pipeline_ctrl_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] ex_rd;
  logic       ex_memread;
  logic       ex_branch_taken;
  logic       dmem_req;
  logic       dmem_ready;

  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_bubble;
  logic       exmem_en;
  logic       memwb_en;
  logic       mem_timeout;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] memwait_cnt;
`endif

  modport master (
    input  id_rs1, id_rs2, ex_rd, ex_memread,
    input  ex_branch_taken, dmem_req, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en,
    output idex_bubble, exmem_en, memwb_en, mem_timeout
`ifdef PIPE_PERF_CNT_EN
    , output stall_cnt, flush_cnt, memwait_cnt
`endif
  );

  modport slave (
    output id_rs1, id_rs2, ex_rd, ex_memread,
    output ex_branch_taken, dmem_req, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en,
    input  idex_bubble, exmem_en, memwb_en, mem_timeout
`ifdef PIPE_PERF_CNT_EN
    , input stall_cnt, flush_cnt, memwait_cnt
`endif
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard term: a load in EX writes a register read in ID.
// x0 is hardwired to zero and never creates a hazard.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       lu
);

  assign lu = ex_memread & (ex_rd != REG_X0) &
              ((id_rs1 == ex_rd) | (id_rs2 == ex_rd));

endmodule

// File: rtl/pipeline_ctrl.sv
// Prioritised stall/flush/freeze sequencer for the 5-stage pipeline.
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush/freeze counters.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.master bus
);

  localparam logic [FCNT_W-1:0] F_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [WCNT_W-1:0] W_LAST   = WCNT_W'(MEM_TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              resume_q, resume_d;

  logic      lu, mw, tmo;
  pipe_ctl_t ctl, ctl_o;

  load_use_detect u_lu (
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .ex_rd      (bus.ex_rd),
    .ex_memread (bus.ex_memread),
    .lu         (lu)
  );

  assign mw = bus.dmem_req & ~bus.dmem_ready;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    fcnt_d   = fcnt_q;
    resume_d = resume_q;
    ctl      = CTL_RUN;
    tmo      = 1'b0;
    unique case (state_q)
      RUN, FLUSH: begin
        if (mw) begin
          ctl      = CTL_FREEZE;
          state_d  = MEM_WAIT;
          wcnt_d   = WCNT_W'(1);
          resume_d = (state_q == FLUSH);
        end else if (bus.ex_branch_taken) begin
          ctl = CTL_FLUSH;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = F_RELOAD;
          end
        end else if (state_q == FLUSH) begin
          ctl = CTL_FLUSH;
          if (fcnt_q == FCNT_W'(1)) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
          end
        end else if (lu) begin
          ctl = CTL_STALL;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_d = resume_q ? FLUSH : RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == W_LAST) begin
          // abort: MEM/WB swallows the dead access, pending flush dropped
          tmo      = 1'b1;
          state_d  = RUN;
          wcnt_d   = '0;
          fcnt_d   = '0;
          resume_d = 1'b0;
        end else begin
          ctl    = CTL_FREEZE;
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d  = RUN;
        wcnt_d   = '0;
        fcnt_d   = '0;
        resume_d = 1'b0;
      end
    endcase
  end

  assign ctl_o = rst_n ? ctl : CTL_RESET;

  assign {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
          bus.idex_bubble, bus.exmem_en, bus.memwb_en} = ctl_o;
  assign bus.mem_timeout = rst_n & tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      wcnt_q   <= '0;
      fcnt_q   <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      fcnt_q   <= fcnt_d;
      resume_q <= resume_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;
  logic [31:0] mwait_q, mwait_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    mwait_d = mwait_q;
    if (ctl == CTL_STALL && stall_q != '1) stall_d = stall_q + 32'd1;
    if (ctl == CTL_FLUSH && flush_q != '1) flush_d = flush_q + 32'd1;
    if (ctl == CTL_FREEZE && mwait_q != '1) mwait_d = mwait_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
      mwait_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      mwait_q <= mwait_d;
    end
  end

  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;
  assign bus.memwait_cnt = mwait_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

  localparam int FC = 2;
  localparam int MT = 4;

  // {pc, ifid_en, ifid_flush, idex_en, idex_bubble, exmem, memwb, timeout}
  localparam logic [7:0] E_RST = 8'b00101000;
  localparam logic [7:0] E_GO  = 8'b11010110;
  localparam logic [7:0] E_STL = 8'b00011110;
  localparam logic [7:0] E_FL  = 8'b11111110;
  localparam logic [7:0] E_FRZ = 8'b00000000;
  localparam logic [7:0] E_TMO = 8'b11010111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .FLUSH_CYCLES (FC),
    .MEM_TIMEOUT  (MT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] outs;
  assign outs = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                 bus.idex_bubble, bus.exmem_en, bus.memwb_en,
                 bus.mem_timeout};

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int r1, input int r2, input int rd,
                       input bit mr, input bit br, input bit rq,
                       input bit rdy);
    bus.id_rs1          = 5'(r1);
    bus.id_rs2          = 5'(r2);
    bus.ex_rd           = 5'(rd);
    bus.ex_memread      = mr;
    bus.ex_branch_taken = br;
    bus.dmem_req        = rq;
    bus.dmem_ready      = rdy;
  endtask

  task automatic idle();
    drive(1, 2, 3, 0, 0, 0, 0);
  endtask

  task automatic step(input string nm, input logic [7:0] exp);
    @(negedge clk);
    chk(nm, outs, exp);
    @(posedge clk);
    #1;
  endtask

  // Model: squash_left = flush cycles still owed; frozen/waited track a
  // data-memory wait where the current cycle is wait cycle waited+1.
  int  squash_left = 0;
  bit  frozen = 0;
  int  waited = 0;

  always @(negedge clk) begin : model_cmp
    logic [7:0] e;
    bit mw, lu;
    e = E_GO;
    if (!rst_n) begin
      e = E_RST;
      squash_left = 0;
      frozen = 0;
      waited = 0;
    end else begin
      mw = bus.dmem_req && !bus.dmem_ready;
      lu = bus.ex_memread && bus.ex_rd != 0 &&
           (bus.id_rs1 == bus.ex_rd || bus.id_rs2 == bus.ex_rd);
      if (frozen) begin
        if (bus.dmem_ready) begin
          e = E_GO;
          frozen = 0;
        end else if (waited + 1 == MT) begin
          e = E_TMO;
          frozen = 0;
          squash_left = 0;
        end else begin
          e = E_FRZ;
          waited = waited + 1;
        end
      end else if (mw) begin
        e = E_FRZ;
        frozen = 1;
        waited = 1;
      end else if (bus.ex_branch_taken || squash_left > 0) begin
        e = E_FL;
        squash_left = (bus.ex_branch_taken ? FC : squash_left) - 1;
      end else if (lu) begin
        e = E_STL;
      end
    end
    chk("model", outs, e);
  end

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step("reset_outs", E_RST);
    rst_n = 1'b1;
    step("idle_run", E_GO);

    drive(5, 9, 5, 1, 0, 0, 0);
    step("lu_stall", E_STL);
    idle();
    step("lu_after", E_GO);

    drive(0, 0, 0, 1, 0, 0, 0);
    step("x0_nostall", E_GO);

    drive(7, 1, 7, 1, 1, 0, 0);
    step("br_lu_1", E_FL);
    idle();
    step("br_lu_2", E_FL);
    step("br_done", E_GO);

    drive(1, 2, 3, 0, 0, 1, 0);
    step("mw_1", E_FRZ);
    step("mw_2", E_FRZ);
    step("mw_3", E_FRZ);
    drive(1, 2, 3, 0, 0, 1, 1);
    step("mw_rel", E_GO);
    idle();
    step("mw_after", E_GO);

    drive(1, 2, 3, 0, 0, 1, 0);
    step("to_1", E_FRZ);
    step("to_2", E_FRZ);
    step("to_3", E_FRZ);
    step("to_pulse", E_TMO);
    idle();
    step("to_after", E_GO);

    drive(1, 2, 3, 0, 1, 0, 0);
    step("fl_mw_br", E_FL);
    drive(1, 2, 3, 0, 0, 1, 0);
    step("fl_mw_frz", E_FRZ);
    drive(1, 2, 3, 0, 0, 1, 1);
    step("fl_mw_rel", E_GO);
    idle();
    step("fl_resume", E_FL);
    step("fl_end", E_GO);

    drive(1, 2, 3, 0, 0, 1, 0);
    step("rw_1", E_FRZ);
    step("rw_2", E_FRZ);
    rst_n = 1'b0;
    step("rw_reset", E_RST);
    rst_n = 1'b1;
    step("rw_cnt0_1", E_FRZ);
    step("rw_cnt0_2", E_FRZ);
    step("rw_cnt0_3", E_FRZ);
    step("rw_cnt0_to", E_TMO);
    idle();

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 2, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    idle();
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
